// File: rtl/ad_acq_pkg.sv
// Shared types and widths for the AD7960 acquisition scheduler.
// State encoding is one-hot; the reload helper applies the minimum-period clamp.
package ad_acq_pkg;

  localparam int unsigned DATA_W         = 18;
  localparam int unsigned CNT_W          = 16;
  localparam int unsigned MIN_PERIOD_DEF = 64;

  typedef enum logic [5:0] {
    StIdle = 6'b000001,
    StTrig = 6'b000010,
    StWait = 6'b000100,
    StGap  = 6'b001000,
    StDone = 6'b010000,
    StErr  = 6'b100000
  } state_e;

  // Period counter reload value P-1, where P = max(period+1, min_period).
  function automatic logic [CNT_W-1:0] period_reload(input logic [CNT_W-1:0] period,
                                                     input int unsigned      min_period);
    logic [CNT_W-1:0] floor_v;
    floor_v = CNT_W'(min_period - 1);
    return (period < floor_v) ? floor_v : period;
  endfunction

endpackage

// File: rtl/ad_acq_outreg.sv
// One-entry valid/ready output stage with sticky overrun flag.
// Optional averaging accumulator enabled by AD_ACQ_AVG_EN.
module ad_acq_outreg
  import ad_acq_pkg::*;
`ifdef AD_ACQ_AVG_EN
#(
  parameter int unsigned AVG_LOG2 = 2
)
`endif
(
  input  logic              fast_clk_i,
  input  logic              reset_n_i,
  input  logic              clr_i,
  input  logic              cap_i,
  input  logic [DATA_W-1:0] cap_data_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              overrun_o
);

  logic              push;
  logic [DATA_W-1:0] push_data;
  logic              can_load;

`ifdef AD_ACQ_AVG_EN
  localparam int unsigned ACC_W = DATA_W + AVG_LOG2;

  logic [ACC_W-1:0]    acc_q;
  logic [ACC_W-1:0]    acc_sum;
  logic [AVG_LOG2-1:0] phase_q;

  assign acc_sum   = acc_q + ACC_W'(cap_data_i);
  assign push      = cap_i && (phase_q == '1);
  assign push_data = DATA_W'(acc_sum >> AVG_LOG2);

  always_ff @(posedge fast_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      acc_q   <= '0;
      phase_q <= '0;
    end else if (clr_i) begin
      acc_q   <= '0;
      phase_q <= '0;
    end else if (cap_i) begin
      phase_q <= phase_q + AVG_LOG2'(1);
      acc_q   <= push ? '0 : acc_sum;
    end
  end
`else
  assign push      = cap_i;
  assign push_data = cap_data_i;
`endif

  // Load is allowed when empty or when the held entry is leaving this cycle.
  assign can_load = !valid_o || ready_i;

  always_ff @(posedge fast_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      valid_o   <= 1'b0;
      data_o    <= '0;
      overrun_o <= 1'b0;
    end else begin
      if (push && can_load) begin
        valid_o <= 1'b1;
        data_o  <= push_data;
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
      if (clr_i) begin
        overrun_o <= 1'b0;
      end else if (push && !can_load) begin
        overrun_o <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ad7960_acq_sched.sv
// Acquisition scheduler: periodic start strobe, ready counting, timeout and overrun.
// Define AD_ACQ_AVG_EN to average 2^AVG_LOG2 captures per output sample.
module ad7960_acq_sched
  import ad_acq_pkg::*;
#(
  parameter int unsigned START_W     = 4,
  parameter int unsigned MIN_PERIOD  = MIN_PERIOD_DEF,
  parameter int unsigned TIMEOUT_CYC = 511
`ifdef AD_ACQ_AVG_EN
  ,
  parameter int unsigned AVG_LOG2    = 2
`endif
) (
  input  logic              fast_clk_i,
  input  logic              reset_n_i,
  input  logic              arm_i,
  input  logic              abort_i,
  input  logic [CNT_W-1:0]  period_i,
  input  logic [CNT_W-1:0]  count_i,
  output logic              adc_start_o,
  input  logic              adc_rdy_i,
  input  logic [DATA_W-1:0] adc_data_i,
  output logic              smp_valid_o,
  output logic [DATA_W-1:0] smp_data_o,
  input  logic              smp_ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              timeout_o,
  output logic              overrun_o,
  output logic [CNT_W-1:0]  smp_cnt_o
);

  localparam int unsigned     TW        = (START_W > 1) ? $clog2(START_W) : 1;
  localparam int unsigned     TO_W      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0]   TRIG_LAST = TW'(START_W - 1);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYC - 1);

  state_e            state_q;
  logic [CNT_W-1:0]  reload_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  per_cnt_q;
  logic [TO_W-1:0]   to_cnt_q;
  logic [TW-1:0]     trig_cnt_q;

  logic [CNT_W-1:0]  reload_in;
  logic [CNT_W-1:0]  smp_cnt_inc;
  logic              arm_ok;
  logic              capture;
  logic              last_smp;

  assign reload_in   = period_reload(period_i, MIN_PERIOD);
  assign arm_ok      = arm_i && !abort_i && (state_q == StIdle);
  assign capture     = adc_rdy_i && !abort_i && (state_q == StWait);
  assign smp_cnt_inc = smp_cnt_o + CNT_W'(1);
  assign last_smp    = (count_q != '0) && (smp_cnt_inc == count_q);

  always_ff @(posedge fast_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= StIdle;
      reload_q    <= '0;
      count_q     <= '0;
      per_cnt_q   <= '0;
      to_cnt_q    <= '0;
      trig_cnt_q  <= '0;
      adc_start_o <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      timeout_o   <= 1'b0;
      smp_cnt_o   <= '0;
    end else begin
      done_o <= 1'b0;
      if (abort_i) begin
        state_q     <= StIdle;
        adc_start_o <= 1'b0;
        busy_o      <= 1'b0;
      end else begin
        // The period counter runs freely between start rises and saturates at 0.
        if (per_cnt_q != '0) per_cnt_q <= per_cnt_q - CNT_W'(1);
        unique case (state_q)
          StIdle: begin
            if (arm_i) begin
              state_q     <= StTrig;
              reload_q    <= reload_in;
              count_q     <= count_i;
              per_cnt_q   <= reload_in;
              to_cnt_q    <= '0;
              trig_cnt_q  <= '0;
              adc_start_o <= 1'b1;
              busy_o      <= 1'b1;
              timeout_o   <= 1'b0;
              smp_cnt_o   <= '0;
            end
          end
          StTrig: begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
            if (trig_cnt_q == TRIG_LAST) begin
              state_q     <= StWait;
              adc_start_o <= 1'b0;
            end else begin
              trig_cnt_q <= trig_cnt_q + TW'(1);
            end
          end
          StWait: begin
            if (adc_rdy_i) begin
              smp_cnt_o <= smp_cnt_inc;
              if (last_smp) begin
                state_q <= StDone;
                done_o  <= 1'b1;
              end else if (per_cnt_q == '0) begin
                // Late ready: period already expired, restart immediately.
                state_q     <= StTrig;
                per_cnt_q   <= reload_q;
                to_cnt_q    <= '0;
                trig_cnt_q  <= '0;
                adc_start_o <= 1'b1;
              end else begin
                state_q <= StGap;
              end
            end else if (to_cnt_q == TO_LAST) begin
              state_q   <= StErr;
              timeout_o <= 1'b1;
              to_cnt_q  <= to_cnt_q + TO_W'(1);
            end else begin
              to_cnt_q <= to_cnt_q + TO_W'(1);
            end
          end
          StGap: begin
            if (per_cnt_q == '0) begin
              state_q     <= StTrig;
              per_cnt_q   <= reload_q;
              to_cnt_q    <= '0;
              trig_cnt_q  <= '0;
              adc_start_o <= 1'b1;
            end
          end
          StDone, StErr: begin
            state_q <= StIdle;
            busy_o  <= 1'b0;
          end
          default: begin
            state_q     <= StIdle;
            adc_start_o <= 1'b0;
            busy_o      <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef AD_ACQ_AVG_EN
  ad_acq_outreg #(
    .AVG_LOG2(AVG_LOG2)
  ) u_outreg (
`else
  ad_acq_outreg u_outreg (
`endif
    .fast_clk_i(fast_clk_i),
    .reset_n_i (reset_n_i),
    .clr_i     (arm_ok),
    .cap_i     (capture),
    .cap_data_i(adc_data_i),
    .ready_i   (smp_ready_i),
    .valid_o   (smp_valid_o),
    .data_o    (smp_data_o),
    .overrun_o (overrun_o)
  );

endmodule

// File: tb/tb_ad7960_acq_sched.sv
// Self-checking bench for ad7960_acq_sched: ADC model feeds a scoreboard of expected
// samples that a monitor pops on each downstream handshake.
module tb_ad7960_acq_sched;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        arm = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] period = '0;
  logic [15:0] count = '0;
  logic        adc_start_o;
  logic        adc_rdy = 1'b0;
  logic [17:0] adc_data = '0;
  logic        smp_valid_o;
  logic [17:0] smp_data_o;
  logic        smp_ready = 1'b1;
  logic        busy_o;
  logic        done_o;
  logic        timeout_o;
  logic        overrun_o;
  logic [15:0] smp_cnt_o;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          hi_len = 0;
  logic        start_prev = 1'b0;
  int          rise_q[$];
  int          width_q[$];
  logic [17:0] exp_q[$];
  logic [17:0] data_q[$];
  logic [17:0] exp_v;

  // ADC model controls
  bit          adc_en = 1'b1;
  bit          push_en = 1'b1;
  int          rdy_dly = 40;
  logic [17:0] adc_val = 18'h00100;
  logic [19:0] m_acc = '0;
  int          m_ph = 0;

  ad7960_acq_sched dut (
    .fast_clk_i (clk),
    .reset_n_i  (reset_n),
    .arm_i      (arm),
    .abort_i    (abort),
    .period_i   (period),
    .count_i    (count),
    .adc_start_o(adc_start_o),
    .adc_rdy_i  (adc_rdy),
    .adc_data_i (adc_data),
    .smp_valid_o(smp_valid_o),
    .smp_data_o (smp_data_o),
    .smp_ready_i(smp_ready),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .timeout_o  (timeout_o),
    .overrun_o  (overrun_o),
    .smp_cnt_o  (smp_cnt_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ADC model: one ready pulse rdy_dly cycles after each start rise.
  initial begin
    logic [17:0] v;
    forever begin
      @(posedge adc_start_o);
      if (adc_en) begin
        repeat (rdy_dly) @(posedge clk);
        #1;
        if (data_q.size() != 0) begin
          v = data_q.pop_front();
        end else begin
          v = adc_val;
          adc_val = adc_val + 18'h00111;
        end
        adc_rdy  = 1'b1;
        adc_data = v;
        if (push_en) begin
`ifdef AD_ACQ_AVG_EN
          m_acc = m_acc + 20'(v);
          m_ph++;
          if (m_ph == 4) begin
            exp_q.push_back(18'(m_acc >> 2));
            m_acc = '0;
            m_ph = 0;
          end
`else
          exp_q.push_back(v);
`endif
        end
        @(posedge clk);
        #1;
        adc_rdy = 1'b0;
      end
    end
  end

  // Monitor: start strobe timing, done pulses, and scoreboard check on handshakes.
  always @(negedge clk) begin
    if (adc_start_o && !start_prev) begin
      rise_q.push_back(cyc);
      hi_len = 0;
    end
    if (adc_start_o) hi_len++;
    if (!adc_start_o && start_prev) width_q.push_back(hi_len);
    start_prev = adc_start_o;
    if (done_o) done_cnt++;
    if (smp_valid_o && smp_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sample_unexpected: got %h, required none", smp_data_o);
      end else begin
        exp_v = exp_q.pop_front();
        if (smp_data_o !== exp_v) begin
          n_err++;
          $display("FAIL sample_data: got %h, required %h", smp_data_o, exp_v);
        end
      end
    end
  end

  task automatic do_arm(input logic [15:0] per, input logic [15:0] cnt);
    @(posedge clk);
    #1;
    period = per;
    count  = cnt;
    arm    = 1'b1;
    m_acc  = '0;
    m_ph   = 0;
    @(posedge clk);
    #1;
    arm = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      if (done_o) seen = 1'b1;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({adc_start_o, smp_valid_o, busy_o, done_o, timeout_o, overrun_o} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_flags: got %b, required 000000",
               {adc_start_o, smp_valid_o, busy_o, done_o, timeout_o, overrun_o});
    end
    n_cmp++;
    if (smp_cnt_o !== 16'd0 || smp_data_o !== 18'd0) begin
      n_err++;
      $display("FAIL reset_counts: got cnt %0d data %h, required 0 0", smp_cnt_o, smp_data_o);
    end
    reset_n = 1'b1;
    // Reset mid-burst returns straight to reset values.
    adc_en = 1'b0;
    do_arm(16'd99, 16'd3);
    repeat (2) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (adc_start_o !== 1'b0 || busy_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_midburst: got start %b busy %b, required 0 0", adc_start_o, busy_o);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    adc_en  = 1'b1;
  endtask

  task automatic test_burst;
    bit seen;
    rise_q.delete();
    width_q.delete();
    done_cnt = 0;
    rdy_dly  = 40;
    do_arm(16'd99, 16'd3);
    wait_done(1000, seen);
    n_cmp++;
    if (seen !== 1'b1) begin
      n_err++;
      $display("FAIL burst_done: got no done_o, required a pulse");
    end
    n_cmp++;
    if (smp_cnt_o !== 16'd3) begin
      n_err++;
      $display("FAIL burst_cnt: got %0d, required 3", smp_cnt_o);
    end
    repeat (5) @(negedge clk);
    n_cmp++;
    if (done_cnt !== 1 || busy_o !== 1'b0) begin
      n_err++;
      $display("FAIL burst_end: got done pulses %0d busy %b, required 1 0", done_cnt, busy_o);
    end
    n_cmp++;
    if (exp_q.size() != 0 || rise_q.size() != 3) begin
      n_err++;
      $display("FAIL burst_counts: got pending %0d rises %0d, required 0 3",
               exp_q.size(), rise_q.size());
    end
    for (int i = 1; i < rise_q.size(); i++) begin
      n_cmp++;
      if (rise_q[i] - rise_q[i-1] !== 100) begin
        n_err++;
        $display("FAIL burst_spacing: got %0d, required 100", rise_q[i] - rise_q[i-1]);
      end
    end
    foreach (width_q[i]) begin
      n_cmp++;
      if (width_q[i] !== 4) begin
        n_err++;
        $display("FAIL start_width: got %0d, required 4", width_q[i]);
      end
    end
  endtask

  task automatic test_clamp;
    bit seen;
    rise_q.delete();
    rdy_dly = 20;
    do_arm(16'd9, 16'd2);
    wait_done(500, seen);
    n_cmp++;
    if (seen !== 1'b1 || rise_q.size() != 2) begin
      n_err++;
      $display("FAIL clamp_done: got done %b rises %0d, required 1 2", seen, rise_q.size());
    end else begin
      n_cmp++;
      if (rise_q[1] - rise_q[0] !== 64) begin
        n_err++;
        $display("FAIL clamp_spacing: got %0d, required 64", rise_q[1] - rise_q[0]);
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_timeout;
    bit seen;
    int t_err;
    rise_q.delete();
    done_cnt = 0;
    adc_en   = 1'b0;
    t_err    = 0;
    seen     = 1'b0;
    do_arm(16'd99, 16'd1);
    for (int i = 0; i < 700 && !seen; i++) begin
      @(negedge clk);
      if (timeout_o) begin
        seen  = 1'b1;
        t_err = cyc;
      end
    end
    n_cmp++;
    if (seen !== 1'b1 || rise_q.size() != 1) begin
      n_err++;
      $display("FAIL timeout_seen: got %b rises %0d, required 1 1", seen, rise_q.size());
    end else begin
      n_cmp++;
      if (t_err - rise_q[0] !== 511) begin
        n_err++;
        $display("FAIL timeout_latency: got %0d, required 511", t_err - rise_q[0]);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (busy_o !== 1'b0 || timeout_o !== 1'b1 || done_cnt !== 0) begin
      n_err++;
      $display("FAIL timeout_state: got busy %b timeout %b done %0d, required 0 1 0",
               busy_o, timeout_o, done_cnt);
    end
    adc_en = 1'b1;
    do_arm(16'd99, 16'd1);
    @(negedge clk);
    n_cmp++;
    if (timeout_o !== 1'b0 || busy_o !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_clear: got timeout %b busy %b, required 0 1", timeout_o, busy_o);
    end
    wait_done(500, seen);
    n_cmp++;
    if (seen !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_rearm_done: got no done_o, required a pulse");
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_overrun;
    bit seen;
    logic [17:0] first;
    smp_ready = 1'b0;
    push_en   = 1'b0;
    rdy_dly   = 40;
    first     = adc_val;
    exp_q.push_back(first);
    do_arm(16'd99, 16'd2);
    wait_done(1000, seen);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (overrun_o !== 1'b1 || smp_cnt_o !== 16'd2) begin
      n_err++;
      $display("FAIL overrun_flag: got ovr %b cnt %0d, required 1 2", overrun_o, smp_cnt_o);
    end
    n_cmp++;
    if (smp_valid_o !== 1'b1 || smp_data_o !== first) begin
      n_err++;
      $display("FAIL overrun_hold: got valid %b data %h, required 1 %h",
               smp_valid_o, smp_data_o, first);
    end
    @(posedge clk);
    #1;
    smp_ready = 1'b1;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (smp_valid_o !== 1'b0 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL overrun_drain: got valid %b pending %0d, required 0 0",
               smp_valid_o, exp_q.size());
    end
    push_en = 1'b1;
  endtask

  task automatic test_abort;
    bit seen;
    int n_rise;
    rise_q.delete();
    done_cnt = 0;
    rdy_dly  = 20;
    seen     = 1'b0;
    do_arm(16'd63, 16'd0);
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (smp_cnt_o == 16'd5) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b1) begin
      n_err++;
      $display("FAIL abort_reach5: got cnt %0d, required 5", smp_cnt_o);
    end
    @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort  = 1'b0;
    n_rise = rise_q.size();
    repeat (200) @(negedge clk);
    n_cmp++;
    if (busy_o !== 1'b0 || adc_start_o !== 1'b0 || rise_q.size() != n_rise) begin
      n_err++;
      $display("FAIL abort_stop: got busy %b start %b rises %0d, required 0 0 %0d",
               busy_o, adc_start_o, rise_q.size(), n_rise);
    end
    n_cmp++;
    if (done_cnt !== 0 || smp_cnt_o !== 16'd5 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL abort_state: got done %0d cnt %0d pending %0d, required 0 5 0",
               done_cnt, smp_cnt_o, exp_q.size());
    end
    @(posedge clk);
    #1;
    period = 16'd99;
    count  = 16'd1;
    arm    = 1'b1;
    abort  = 1'b1;
    @(posedge clk);
    #1;
    arm   = 1'b0;
    abort = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (busy_o !== 1'b0 || rise_q.size() != n_rise || smp_cnt_o !== 16'd5) begin
      n_err++;
      $display("FAIL arm_abort: got busy %b rises %0d cnt %0d, required 0 %0d 5",
               busy_o, rise_q.size(), smp_cnt_o, n_rise);
    end
  endtask

`ifdef AD_ACQ_AVG_EN
  task automatic test_avg;
    bit seen;
    rdy_dly = 20;
    data_q.push_back(18'd10);
    data_q.push_back(18'd11);
    data_q.push_back(18'd12);
    data_q.push_back(18'd14);
    exp_q.delete();
    do_arm(16'd99, 16'd4);
    wait_done(1000, seen);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (seen !== 1'b1 || smp_cnt_o !== 16'd4 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL avg_burst: got done %b cnt %0d pending %0d, required 1 4 0",
               seen, smp_cnt_o, exp_q.size());
    end
    n_cmp++;
    if (smp_data_o !== 18'd11) begin
      n_err++;
      $display("FAIL avg_value: got %0d, required 11", smp_data_o);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_burst();
    test_clamp();
    test_timeout();
`ifdef AD_ACQ_AVG_EN
    test_abort();
    test_avg();
`else
    test_overrun();
    test_abort();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ad7960_acq_sched.md
Name: ad7960_acq_sched

Overview:
- Acquisition scheduler for the AD7960 serial controller. Generates that controller's start strobe at a programmable sample period and counts ready pulses against a requested burst length.
- Captures each 18-bit result into a one-entry valid/ready output stage for downstream buffering.
- Detects a missing ready pulse (timeout) and downstream backpressure loss (overrun).

Parameters:
- START_W, 4, width in cycles of adc_start_o high pulse; must exceed the ADC controller start-sync delay.
- MIN_PERIOD, 64, lower clamp on the sample period in cycles.
- TIMEOUT_CYC, 511, maximum cycles from start rise to adc_rdy_i before error.

Ports:
- fast_clk_i  in  1  single clock, up to 300 MHz.
- reset_n_i  in  1  asynchronous reset, active low.
- arm_i  in  1  one-cycle pulse; starts a burst; ignored unless IDLE.
- abort_i  in  1  one-cycle pulse; ends any burst.
- period_i  in  16  sample period minus 1, in cycles; latched on arm.
- count_i  in  16  samples per burst, latched on arm; 0 = continuous until abort.
- adc_start_o  out  1  start strobe to the AD7960 controller.
- adc_rdy_i  in  1  one-cycle data-ready pulse from the AD7960 controller.
- adc_data_i  in  18  conversion result, valid while adc_rdy_i is high.
- smp_valid_o  out  1  output sample valid.
- smp_data_o  out  18  output sample.
- smp_ready_i  in  1  downstream accept.
- busy_o  out  1  high in any state other than IDLE.
- done_o  out  1  one-cycle pulse at burst completion.
- timeout_o  out  1  sticky; cleared on arm.
- overrun_o  out  1  sticky; cleared on arm.
- smp_cnt_o  out  16  samples captured in the current burst.

Behaviour:
- Reset values: all outputs 0; state IDLE.
- States:
  - IDLE -> TRIG on arm_i.
  - TRIG -> WAIT when the start pulse ends (START_W cycles).
  - WAIT -> GAP on adc_rdy_i when samples remain, or when count is 0.
  - WAIT -> DONE on adc_rdy_i when the last sample is captured.
  - WAIT -> ERR when the timeout counter reaches TIMEOUT_CYC.
  - GAP -> TRIG when the period counter expires.
  - DONE -> IDLE after 1 cycle.
  - ERR -> IDLE after 1 cycle.
- Arm: period and count latched in the arm cycle; timeout_o, overrun_o and smp_cnt_o are cleared.
- Start strobe: adc_start_o rises in the first TRIG cycle and stays high exactly START_W cycles.
- Period: effective period P = max(period_i+1, MIN_PERIOD).
  - The period counter loads P-1 on each entry to TRIG; start-rise to start-rise spacing is exactly P cycles.
  - If adc_rdy_i arrives after the period has already expired, TRIG is entered on the cycle after the capture. The period stretches and nothing is lost.
- Timeout counter: reset on each start rise; counts in TRIG and WAIT.
- adc_rdy_i outside WAIT: ignored, with no capture.
- Capture, when adc_rdy_i is high in WAIT:
  - If the output stage is empty, or is being accepted in the same cycle, smp_data_o <= adc_data_i and smp_valid_o <= 1 on the next edge.
  - Otherwise the sample is dropped and overrun_o <= 1.
  - smp_cnt_o increments either way, wrapping at 16 bits in continuous mode.
- Output stage: smp_valid_o clears on valid&&ready unless a new capture happens in the same cycle. Data stays stable while valid&&!ready.
- done_o: pulses in the DONE cycle. Not generated in ERR or on abort.
- ERR: timeout_o <= 1.
- abort_i: highest priority in any state. Next state is IDLE, adc_start_o drops on the next edge, and a pending output sample is retained.
- arm_i and abort_i in the same cycle: abort wins and arm is ignored.
- Reset mid-burst: immediate return to reset values.

Optional Feature:
- Macro: AD_ACQ_AVG_EN.
- When defined:
  - Adds parameter AVG_LOG2 (default 2).
  - 2^AVG_LOG2 consecutive captures are summed in a (18+AVG_LOG2)-bit unsigned accumulator.
  - Only the sum >> AVG_LOG2 (truncating) is presented on smp_data_o.
  - smp_cnt_o and count_i count raw conversions; the accumulator clears on arm.
- When undefined: every capture is presented directly and no accumulator logic exists.

Decomposition:
- Package ad_acq_pkg holds:
  - the state encoding (one-hot, 6 states);
  - the field widths (DATA_W=18, CNT_W=16);
  - the MIN_PERIOD default.
- One sub-module, ad_acq_outreg: the one-entry valid/ready output stage with overrun detect, including the optional accumulator.

Test Plan:
- period_i=99, count_i=3, ADC model with ready 40 cycles after start -> adc_start_o rises are 100 cycles apart and each is 4 cycles wide; samples A,B,C are delivered in order; done_o pulses once; smp_cnt_o=3.
- period_i=9 -> spacing clamped to 64 cycles.
- ADC model never asserts ready -> ERR reached 511 cycles after the start rise; timeout_o=1; busy_o=0; done_o never pulses; the next arm clears timeout_o.
- smp_ready_i held 0, count_i=2 -> first sample held stable, second dropped, overrun_o=1; releasing smp_ready_i yields the first sample only.
- count_i=0, abort_i after 5 samples -> adc_start_o stops, returns to IDLE, no done_o; arm_i and abort_i in the same cycle from IDLE -> stays IDLE.
- AD_ACQ_AVG_EN with AVG_LOG2=2, inputs 10,11,12,14 -> one output of 11, with count_i=4.
